// File: rtl/request_fifo_dispatcher.sv
// Pops packed request entries from the AXI request FIFO, splits the address into
// tag/index/offset and presents the decoded request to the tag-lookup stage.
module request_fifo_dispatcher #(
    parameter int ADDR_W   = 32,
    parameter int ID_W     = 32,
    parameter int SLAVE_W  = 4,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 10,
    parameter int CNT_W    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fifo_empty,
    output logic                            fifo_rd_en,
    input  logic [127:0]                    fifo_o,
    output logic                            req_valid_o,
    input  logic                            req_ready_i,
    output logic                            req_is_write_o,
    output logic [ID_W-1:0]                 req_id_o,
    output logic [SLAVE_W-1:0]              req_slave_o,
    output logic [ADDR_W-1:0]               req_addr_o,
    output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] req_tag_o,
    output logic [INDEX_W-1:0]              req_index_o,
    output logic [OFFSET_W-1:0]             req_offset_o,
    output logic [CNT_W-1:0]                rd_cnt_o,
    output logic [CNT_W-1:0]                wr_cnt_o,
    output logic                            err_o
);

    localparam int SLV_LSB = ADDR_W + ID_W;
    localparam int WR_BIT  = ADDR_W + ID_W + SLAVE_W;
    localparam int RSV_LSB = WR_BIT + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 is_write_q, is_write_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [SLAVE_W-1:0]   slave_q, slave_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [CNT_W-1:0]     rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic                 err_q, err_d;

    logic                 malformed;
    logic                 handshake;
    logic                 pop;

    assign malformed = |fifo_o[127:RSV_LSB];
    assign handshake = (state_q == S_VALID) && req_ready_i;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        is_write_d = is_write_q;
        id_d       = id_q;
        slave_d    = slave_q;
        addr_d     = addr_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // Entries with reserved bits set are dropped and leave the held fields alone.
                if (malformed) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    is_write_d = fifo_o[WR_BIT];
                    slave_d    = fifo_o[WR_BIT-1:SLV_LSB];
                    id_d       = fifo_o[SLV_LSB-1:ADDR_W];
                    addr_d     = fifo_o[ADDR_W-1:0];
                    state_d    = S_VALID;
                end
            end
            S_VALID: begin
                if (handshake) begin
                    if (is_write_q) begin
                        if (wr_cnt_q != {CNT_W{1'b1}}) begin
                            wr_cnt_d = wr_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        if (rd_cnt_q != {CNT_W{1'b1}}) begin
                            rd_cnt_d = rd_cnt_q + CNT_W'(1);
                        end
                    end
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_write_q <= 1'b0;
            id_q       <= '0;
            slave_q    <= '0;
            addr_q     <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            id_q       <= id_d;
            slave_q    <= slave_d;
            addr_q     <= addr_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            err_q      <= err_d;
        end
    end

    // No pop may leave while reset is held; the FIFO would lose an entry.
    assign fifo_rd_en     = pop && !rst;
    assign req_valid_o    = (state_q == S_VALID);
    assign req_is_write_o = is_write_q;
    assign req_id_o       = id_q;
    assign req_slave_o    = slave_q;
    assign req_addr_o     = addr_q;
    assign req_tag_o      = addr_q[ADDR_W-1:OFFSET_W+INDEX_W];
    assign req_index_o    = addr_q[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign req_offset_o   = addr_q[OFFSET_W-1:0];
    assign rd_cnt_o       = rd_cnt_q;
    assign wr_cnt_o       = wr_cnt_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_request_fifo_dispatcher.sv
// Directed bench for request_fifo_dispatcher: a queue-backed FIFO model feeds two
// instances (default and 2-bit counters) and every step compares against hand values.
module tb_request_fifo_dispatcher;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [127:0] fifo_o;
    logic         req_valid_o;
    logic         req_ready_i;
    logic         req_is_write_o;
    logic [31:0]  req_id_o;
    logic [3:0]   req_slave_o;
    logic [31:0]  req_addr_o;
    logic [15:0]  req_tag_o;
    logic [9:0]   req_index_o;
    logic [5:0]   req_offset_o;
    logic [15:0]  rd_cnt_o;
    logic [15:0]  wr_cnt_o;
    logic         err_o;

    logic         fifo_rd_en2;
    logic         req_valid2;
    logic         req_is_write2;
    logic [31:0]  req_id2;
    logic [3:0]   req_slave2;
    logic [31:0]  req_addr2;
    logic [15:0]  req_tag2;
    logic [9:0]   req_index2;
    logic [5:0]   req_offset2;
    logic [1:0]   rd_cnt2;
    logic [1:0]   wr_cnt2;
    logic         err2;

    int passed = 0;
    int total  = 0;

    logic [127:0] q[$];
    logic [127:0] expq[$];
    logic         pop_pend = 1'b0;

    always #5 clk = ~clk;

    request_fifo_dispatcher dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_o(fifo_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_is_write_o(req_is_write_o), .req_id_o(req_id_o), .req_slave_o(req_slave_o),
        .req_addr_o(req_addr_o), .req_tag_o(req_tag_o), .req_index_o(req_index_o),
        .req_offset_o(req_offset_o), .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o),
        .err_o(err_o)
    );

    request_fifo_dispatcher #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en2),
        .fifo_o(fifo_o), .req_valid_o(req_valid2), .req_ready_i(req_ready_i),
        .req_is_write_o(req_is_write2), .req_id_o(req_id2), .req_slave_o(req_slave2),
        .req_addr_o(req_addr2), .req_tag_o(req_tag2), .req_index_o(req_index2),
        .req_offset_o(req_offset2), .rd_cnt_o(rd_cnt2), .wr_cnt_o(wr_cnt2),
        .err_o(err2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] ent(input logic w, input logic [3:0] s,
                                         input logic [31:0] id, input logic [31:0] a);
        return {59'd0, w, s, id, a};
    endfunction

    function automatic int sat2(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic push_raw(input logic [127:0] e);
        q.push_back(e);
        fifo_empty = 1'b0;
    endtask

    task automatic push_exp(input logic [127:0] e);
        push_raw(e);
        expq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_cnt(input int rd_exp, input int wr_exp);
        chk("rd_cnt", rd_cnt_o, rd_exp);
        chk("wr_cnt", wr_cnt_o, wr_exp);
        chk("rd_cnt_sat2", rd_cnt2, sat2(rd_exp));
        chk("wr_cnt_sat2", wr_cnt2, sat2(wr_exp));
    endtask

    // Starts in IDLE with ready high and the expected entries queued; leaves in IDLE.
    task automatic drain_burst(input int n);
        logic [127:0] e;
        for (int i = 0; i < n; i++) begin
            e = expq.pop_front();
            chk("burst_pop", fifo_rd_en, 1);
            tick();
            chk("burst_fetch_valid", req_valid_o, 0);
            chk("burst_fetch_rden", fifo_rd_en, 0);
            tick();
            chk("burst_valid", req_valid_o, 1);
            chk("burst_addr", req_addr_o, e[31:0]);
            chk("burst_id", req_id_o, e[63:32]);
            chk("burst_slave", req_slave_o, e[67:64]);
            chk("burst_is_write", req_is_write_o, e[68]);
            chk("burst_next_pop", fifo_rd_en, (i < n - 1) ? 1 : 0);
        end
        tick();
        chk("burst_end_valid", req_valid_o, 0);
    endtask

    // FIFO model: a pop seen in a cycle delivers its entry just after the next edge.
    always @(negedge clk) begin
        pop_pend = fifo_rd_en;
        if (fifo_rd_en) chk("rd_en_while_empty", fifo_empty, 0);
    end

    always @(posedge clk) begin
        #1;
        if (pop_pend) begin
            if (q.size() == 0) begin
                chk("fifo_underflow", 1, 0);
            end else begin
                fifo_o = q.pop_front();
            end
        end
        fifo_empty = (q.size() == 0);
    end

    initial begin
        rst         = 1'b1;
        req_ready_i = 1'b1;
        fifo_empty  = 1'b1;
        fifo_o      = '0;

        // Reset held two cycles with an entry available
        push_exp(ent(1'b0, 4'd3, 32'd5, 32'h0001_2345));
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_valid", req_valid_o, 0);
            chk("rst_addr", req_addr_o, 0);
            chk("rst_id", req_id_o, 0);
            chk("rst_err", err_o, 0);
            chk_cnt(0, 0);
        end
        rst = 1'b0;
        #1;

        // Single read, latency and field split
        chk("t2_pop", fifo_rd_en, 1);
        void'(expq.pop_front());
        tick();
        chk("t2_fetch_valid", req_valid_o, 0);
        tick();
        chk("t2_valid", req_valid_o, 1);
        chk("t2_tag", req_tag_o, 16'h0001);
        chk("t2_index", req_index_o, 10'h08D);
        chk("t2_offset", req_offset_o, 6'h05);
        chk("t2_slave", req_slave_o, 4'd3);
        chk("t2_id", req_id_o, 32'd5);
        chk("t2_is_write", req_is_write_o, 0);
        tick();
        chk("t2_after_valid", req_valid_o, 0);
        chk_cnt(1, 0);

        // Four back-to-back entries, one bubble each
        push_exp(ent(1'b0, 4'd1, 32'h10, 32'h0000_1000));
        push_exp(ent(1'b1, 4'd2, 32'h11, 32'h0000_2040));
        push_exp(ent(1'b0, 4'd4, 32'h12, 32'h0000_3080));
        push_exp(ent(1'b1, 4'd8, 32'h13, 32'h0000_40C0));
        #1;
        drain_burst(4);
        chk_cnt(3, 2);

        // Backpressure: fields held, no pop until accepted
        req_ready_i = 1'b0;
        push_raw(ent(1'b1, 4'd9, 32'h77, 32'hDEAD_BEEF));
        push_raw(ent(1'b0, 4'd6, 32'h78, 32'h0000_0040));
        #1;
        chk("t4_pop", fifo_rd_en, 1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", req_valid_o, 1);
            chk("t4_hold_addr", req_addr_o, 32'hDEAD_BEEF);
            chk("t4_hold_id", req_id_o, 32'h77);
            chk("t4_hold_no_pop", fifo_rd_en, 0);
            tick();
        end
        chk("t4_tag", req_tag_o, 16'hDEAD);
        chk("t4_index", req_index_o, 10'h2FB);
        chk("t4_offset", req_offset_o, 6'h2F);
        chk_cnt(3, 2);
        req_ready_i = 1'b1;
        #1;
        chk("t4_accept_pop", fifo_rd_en, 1);
        tick();
        chk("t4_fetch_valid", req_valid_o, 0);
        chk_cnt(3, 3);
        tick();
        chk("t4_second_valid", req_valid_o, 1);
        chk("t4_second_id", req_id_o, 32'h78);
        chk("t4_second_no_pop", fifo_rd_en, 0);
        tick();
        chk("t4_idle_valid", req_valid_o, 0);
        chk_cnt(4, 3);

        // Malformed entry dropped, sticky error, next entry still served
        push_raw(ent(1'b1, 4'd2, 32'h98, 32'h0000_0800) | (128'd1 << 100));
        push_raw(ent(1'b0, 4'd5, 32'h99, 32'h0000_1000));
        #1;
        chk("t5_pop_bad", fifo_rd_en, 1);
        tick();
        chk("t5_err_before", err_o, 0);
        tick();
        chk("t5_err_set", err_o, 1);
        chk("t5_drop_valid", req_valid_o, 0);
        chk("t5_pop_good", fifo_rd_en, 1);
        chk_cnt(4, 3);
        tick();
        chk("t5_fetch_valid", req_valid_o, 0);
        tick();
        chk("t5_good_valid", req_valid_o, 1);
        chk("t5_good_id", req_id_o, 32'h99);
        chk("t5_err_sticky", err_o, 1);
        tick();
        chk_cnt(5, 3);
        chk("t5_err_still", err_o, 1);

        // Write counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) begin
            push_exp(ent(1'b1, 4'(i), 32'h200 + 32'(i), 32'(i) * 32'h40));
        end
        #1;
        drain_burst(5);
        chk_cnt(5, 8);

        // Reset arriving while a pop is in flight
        push_raw(ent(1'b0, 4'd1, 32'h55, 32'h0000_0100));
        #1;
        chk("t6_pop", fifo_rd_en, 1);
        tick();
        chk("t6_fetch_valid", req_valid_o, 0);
        rst = 1'b1;
        #1;
        chk("t6_rst_rd_en", fifo_rd_en, 0);
        tick();
        chk("t6_rst_valid", req_valid_o, 0);
        chk("t6_rst_err", err_o, 0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t6_post_valid", req_valid_o, 0);
            chk("t6_post_addr", req_addr_o, 0);
        end
        chk_cnt(0, 0);

        push_exp(ent(1'b0, 4'd7, 32'h66, 32'h0000_0ABC));
        #1;
        drain_burst(1);
        chk_cnt(1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
